// File: rtl/vend_session_ctrl.sv
// Vending session controller: coin credit, price-table selection, dispense handshake,
// unit-coin change payout, cancel refund and inactivity timeout.
module vend_session_ctrl #(
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 20,
    parameter int PRICE_DEF  = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    output logic                coin_accept,
    output logic                coin_reject,
    input  logic                sel_valid,
    input  logic [1:0]          sel_id,
    output logic                sel_denied,
    input  logic                cancel,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_addr,
    input  logic [CREDIT_W-1:0] cfg_price,
    output logic                disp_req,
    output logic [1:0]          disp_id,
    input  logic                disp_ack,
    output logic                chg_req,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

    localparam int                TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CREDIT_W:0] MAX_SUM  = (CREDIT_W + 1)'(MAX_CREDIT);

    state_t              r_state, w_state_next;
    logic [CREDIT_W-1:0] r_credit, w_credit_next;
    logic [TMR_W-1:0]    r_timer, w_timer_next;
    logic [1:0]          r_disp_id, w_disp_id_next;
    logic                r_coin_accept, w_coin_accept_next;
    logic                r_coin_reject, w_coin_reject_next;
    logic                r_sel_denied, w_sel_denied_next;
    logic                r_disp_req, r_chg_req, r_busy;

    logic [CREDIT_W-1:0] w_price [4];
    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W:0]   w_coin_sum;
    logic [CREDIT_W-1:0] w_sel_price;
    logic                w_coin_ok, w_sel_ok, w_chg_pay;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_price
            logic [CREDIT_W-1:0] r_entry;
            always_ff @(posedge clk) begin
                if (rst)
                    r_entry <= CREDIT_W'(PRICE_DEF);
                else if (cfg_we && cfg_addr == 2'(gi))
                    r_entry <= cfg_price;
            end
            assign w_price[gi] = r_entry;
        end
    endgenerate

    always_comb begin
        w_coin_val = '0;
        case (coin_type)
            2'b00:   w_coin_val = CREDIT_W'(1);
            2'b01:   w_coin_val = CREDIT_W'(2);
            2'b10:   w_coin_val = CREDIT_W'(5);
            default: w_coin_val = '0;
        endcase
    end

    // Sum is one bit wider so an overflowing coin can never wrap past the limit check.
    assign w_coin_sum  = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_coin_ok   = (coin_type != 2'b11) && (w_coin_sum <= MAX_SUM);
    assign w_sel_price = w_price[sel_id];
    assign w_sel_ok    = (w_sel_price != '0) && (r_credit >= w_sel_price);
    assign w_chg_pay   = r_chg_req && chg_ack;

    always_comb begin
        w_state_next       = r_state;
        w_credit_next      = r_credit;
        w_timer_next       = '0;
        w_disp_id_next     = r_disp_id;
        w_coin_accept_next = 1'b0;
        w_coin_reject_next = 1'b0;
        w_sel_denied_next  = 1'b0;
        case (r_state)
            S_IDLE, S_CREDIT: begin
                if (r_state == S_CREDIT && !coin_valid && !sel_valid)
                    w_timer_next = r_timer + TMR_W'(1);
                if (cancel && r_state == S_CREDIT) begin
                    w_state_next       = S_CHANGE;
                    w_coin_reject_next = coin_valid;
                end else if (sel_valid) begin
                    w_coin_reject_next = coin_valid;
                    if (w_sel_ok) begin
                        w_credit_next  = r_credit - w_sel_price;
                        w_state_next   = S_VEND;
                        w_disp_id_next = sel_id;
                    end else begin
                        w_sel_denied_next = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (w_coin_ok) begin
                        w_credit_next      = w_coin_sum[CREDIT_W-1:0];
                        w_coin_accept_next = 1'b1;
                        w_state_next       = S_CREDIT;
                    end else begin
                        w_coin_reject_next = 1'b1;
                    end
                end else if (r_state == S_CREDIT && r_timer == TMR_LAST) begin
                    w_state_next = S_CHANGE;
                end
                if (w_state_next != S_CREDIT)
                    w_timer_next = '0;
            end
            S_VEND: begin
                w_coin_reject_next = coin_valid;
                if (disp_ack)
                    w_state_next = (r_credit != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                w_coin_reject_next = coin_valid;
                if (w_chg_pay) begin
                    w_credit_next = r_credit - CREDIT_W'(1);
                    if (r_credit == CREDIT_W'(1))
                        w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_timer       <= '0;
            r_disp_id     <= '0;
            r_coin_accept <= 1'b0;
            r_coin_reject <= 1'b0;
            r_sel_denied  <= 1'b0;
            r_disp_req    <= 1'b0;
            r_chg_req     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_credit      <= w_credit_next;
            r_timer       <= w_timer_next;
            r_disp_id     <= w_disp_id_next;
            r_coin_accept <= w_coin_accept_next;
            r_coin_reject <= w_coin_reject_next;
            r_sel_denied  <= w_sel_denied_next;
            r_disp_req    <= (w_state_next == S_VEND);
            r_chg_req     <= (w_state_next == S_CHANGE) && (w_credit_next != '0);
            r_busy        <= (w_state_next == S_VEND) || (w_state_next == S_CHANGE);
        end
    end

    assign coin_accept = r_coin_accept;
    assign coin_reject = r_coin_reject;
    assign sel_denied  = r_sel_denied;
    assign disp_req    = r_disp_req;
    assign disp_id     = r_disp_id;
    assign chg_req     = r_chg_req;
    assign credit      = r_credit;
    assign busy        = r_busy;

endmodule
